// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } hz_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A writing, non-x0 destination that names the given source register.
  function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX-stage forwarding select: EX/MEM result beats MEM/WB result, x0 never forwarded.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_regwrite,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_regwrite,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  always_comb begin
    forward_a = FWD_RF;
    forward_b = FWD_RF;
    if (ENABLE) begin
      if (reg_match(exmem_regwrite, exmem_rd, rs1)) begin
        forward_a = FWD_EXMEM;
      end else if (reg_match(memwb_regwrite, memwb_rd, rs1)) begin
        forward_a = FWD_MEMWB;
      end
      if (reg_match(exmem_regwrite, exmem_rd, rs2)) begin
        forward_b = FWD_EXMEM;
      end else if (reg_match(memwb_regwrite, memwb_rd, rs2)) begin
        forward_b = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline enable/flush sequencer with data-memory handshake and forwarding select.
// Build macro HAZARD_FWD_EN: enables forwarding; otherwise RAW hazards stall until writeback.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             id_ex_regwrite,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_regwrite,
  input  logic             ex_mem_memread,
  input  logic             ex_mem_memwrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_regwrite,
  input  logic             ex_branch_taken,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  import pipe_ctrl_pkg::*;

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

`ifdef HAZARD_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q;
  logic [1:0]        fwd_a, fwd_b;
  logic              mem_access, load_use, raw_hit, data_haz, mem_stall;

  assign mem_access = ex_mem_memread | ex_mem_memwrite;
  assign load_use   = id_ex_memread && (id_ex_rd != REG_ZERO) &&
                      ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));
  // Without bypassing, any in-flight writer of an ID source must drain through WB first.
  assign raw_hit    = reg_match(id_ex_regwrite, id_ex_rd, id_rs1) |
                      reg_match(id_ex_regwrite, id_ex_rd, id_rs2) |
                      reg_match(ex_mem_regwrite, ex_mem_rd, id_rs1) |
                      reg_match(ex_mem_regwrite, ex_mem_rd, id_rs2) |
                      reg_match(mem_wb_regwrite, mem_wb_rd, id_rs1) |
                      reg_match(mem_wb_regwrite, mem_wb_rd, id_rs2);
  assign data_haz   = load_use | (!FWD_ON & raw_hit);

  pipe_fwd_unit #(
    .ENABLE(FWD_ON)
  ) u_fwd (
    .rs1            (id_ex_rs1),
    .rs2            (id_ex_rs2),
    .exmem_rd       (ex_mem_rd),
    .exmem_regwrite (ex_mem_regwrite),
    .memwb_rd       (mem_wb_rd),
    .memwb_regwrite (mem_wb_regwrite),
    .forward_a      (fwd_a),
    .forward_b      (fwd_b)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    mem_stall   = 1'b0;
    mem_err     = 1'b0;
    dmem_req    = 1'b0;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    forward_a   = fwd_a;
    forward_b   = fwd_b;

    unique case (state_q)
      ST_RUN: begin
        dmem_req = mem_access;
        if (mem_access && !dmem_ack) begin
          mem_stall = 1'b1;
          state_d   = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = ST_RUN;
        end else if (wait_q == WAIT_LAST) begin
          mem_err = 1'b1;
          state_d = ST_RUN;
        end else begin
          mem_stall = 1'b1;
          wait_d    = wait_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // A branch held across a memory stall is applied on the release cycle.
    if (mem_stall) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (data_haz) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    if (rst) begin
      state_d     = ST_RUN;
      wait_d      = '0;
      mem_err     = 1'b0;
      dmem_req    = 1'b0;
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      forward_a   = FWD_RF;
      forward_b   = FWD_RF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!pc_en && !(&stall_q)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_q;

endmodule
